// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Drives the board TXD pin from one of NUM_SRC on-chip UART transmitters.
// The owner of the pin only changes at frame-safe idle boundaries: either on
// an explicit request once both old and new sources have rested at mark for
// GUARD_CYCLES, or automatically when an idle source starts a frame while the
// current owner is idle. Start bits that cannot reach the pin are counted.
`timescale 1ns/1ps

module uart_tx_arbiter #(
    parameter int NUM_SRC     = 2,
    parameter int BAUD_PERIOD = 868,
    parameter int GUARD_BITS  = 11,
    parameter int DEFAULT_SEL = 0,
    localparam int SEL_W        = $clog2(NUM_SRC),
    localparam int GUARD_CYCLES = GUARD_BITS * BAUD_PERIOD,
    localparam int CNT_W        = $clog2(GUARD_CYCLES + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sync_reset,
    input  logic [NUM_SRC-1:0] tx_in,
    input  logic               sel_mode,
    input  logic [SEL_W-1:0]   sel_req,
    output logic               TXD,
    output logic [SEL_W-1:0]   sel_current,
    output logic               switch_pending,
    output logic               switch_pulse,
    output logic [7:0]         dropped_cnt
);

    // Selection policy, decoded from the sel_mode pin.
    typedef enum logic {
        MODE_EXPLICIT = 1'b0,
        MODE_AUTO     = 1'b1
    } mode_e;

    localparam logic [CNT_W-1:0] GUARD_MAX = CNT_W'(GUARD_CYCLES);
    localparam logic [SEL_W-1:0] SEL_RESET = SEL_W'(DEFAULT_SEL);
    localparam logic [SEL_W:0]   NUM_SRC_V = (SEL_W + 1)'(NUM_SRC);
    localparam int               DROP_W    = $clog2(NUM_SRC + 1);

    mode_e mode;

    // Per-source line state.
    logic [CNT_W-1:0]   idle_cnt [NUM_SRC];
    logic [NUM_SRC-1:0] tx_prev;
    logic [NUM_SRC-1:0] idle;
    logic [NUM_SRC-1:0] start;

    // Selection state and decisions.
    logic               cur_idle;
    logic               req_idle;
    logic               req_in_range;
    logic               req_valid;
    logic               auto_found;
    logic [SEL_W-1:0]   auto_sel;
    logic [SEL_W-1:0]   sel_next;
    logic               txd_next;

    // Dropped-frame accounting.
    logic [DROP_W-1:0]  drop_now;
    logic [8:0]         drop_sum;
    logic [7:0]         dropped_next;

    assign mode = mode_e'(sel_mode);

    // Idle flags come from the registered counters; a start is a falling edge
    // on a line that had been resting at mark for the full guard time.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // can leave it unassigned and infer a latch.
        idle  = '0;
        start = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idle[i]  = (idle_cnt[i] == GUARD_MAX);
            start[i] = tx_prev[i] & ~tx_in[i] & idle[i];
        end
    end

    // Look up the idle state of the current owner and of the requested
    // source; an out-of-range request never matches and so reads as busy.
    always_comb begin
        cur_idle = 1'b0;
        req_idle = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (SEL_W'(i) == sel_current) begin
                cur_idle = idle[i];
            end
            if (SEL_W'(i) == sel_req) begin
                req_idle = idle[i];
            end
        end
    end

    // An explicit request only counts when it names a real, different source.
    always_comb begin
        req_in_range = ({1'b0, sel_req} < NUM_SRC_V);
        req_valid    = req_in_range && (sel_req != sel_current);
    end

    // Auto mode candidate: lowest-numbered other source showing a start bit.
    always_comb begin
        auto_found = 1'b0;
        auto_sel   = sel_current;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!auto_found && start[i] && (SEL_W'(i) != sel_current)) begin
                auto_found = 1'b1;
                auto_sel   = SEL_W'(i);
            end
        end
    end

    // Choose the next owner; a busy current owner blocks every change, so a
    // partial character never reaches the pin.
    always_comb begin
        sel_next = sel_current;
        case (mode)
            MODE_EXPLICIT: begin
                if (req_valid && cur_idle && req_idle) begin
                    sel_next = sel_req;
                end
            end
            MODE_AUTO: begin
                if (cur_idle && auto_found) begin
                    sel_next = auto_sel;
                end
            end
            default: begin
                sel_next = sel_current;
            end
        endcase
    end

    // A request is pending while it is legal but the idle condition still
    // holds it back; auto mode never has anything pending.
    assign switch_pending = (mode == MODE_EXPLICIT) && req_valid &&
                            !(cur_idle && req_idle);

    // Pick the bit of the next owner, so a granted start bit goes straight out.
    always_comb begin
        txd_next = 1'b1;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (SEL_W'(i) == sel_next) begin
                txd_next = tx_in[i];
            end
        end
    end

    // Count every start on a line that will not own the pin next cycle,
    // including the losers of a simultaneous auto start; saturate at 255.
    always_comb begin
        drop_now = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (start[i] && (SEL_W'(i) != sel_next)) begin
                drop_now = drop_now + DROP_W'(1);
            end
        end
        drop_sum     = {1'b0, dropped_cnt} + 9'(drop_now);
        dropped_next = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
    end

    // Track how long each line has rested at mark, plus its previous level.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: the idle counter array is reset explicitly; it decides when a
        // switch is safe, so it must restart from zero after any reset.
        if (!reset_n) begin
            tx_prev <= '1;
            for (int i = 0; i < NUM_SRC; i++) begin
                idle_cnt[i] <= '0;
            end
        end else if (sync_reset) begin
            tx_prev <= '1;
            for (int i = 0; i < NUM_SRC; i++) begin
                idle_cnt[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register updates from values sampled before the edge.
            tx_prev <= tx_in;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!tx_in[i]) begin
                    idle_cnt[i] <= '0;
                end else if (idle_cnt[i] != GUARD_MAX) begin
                    idle_cnt[i] <= idle_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Registered pin, owner, switch strobe and dropped-frame counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            TXD          <= 1'b1;
            sel_current  <= SEL_RESET;
            switch_pulse <= 1'b0;
            dropped_cnt  <= 8'd0;
        end else if (sync_reset) begin
            TXD          <= 1'b1;
            sel_current  <= SEL_RESET;
            switch_pulse <= 1'b0;
            dropped_cnt  <= 8'd0;
        end else begin
            TXD          <= txd_next;
            sel_current  <= sel_next;
            switch_pulse <= (sel_next != sel_current);
            dropped_cnt  <= dropped_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter (NUM_SRC=3, BAUD_PERIOD=4, GUARD_BITS=2).
// Stimulus pushes the expected post-edge state into a queue; a monitor pops
// and compares one cycle later. Switch strobes are checked against a
// separate queue of expected new owners.
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

    localparam int NUM_SRC = 3;
    localparam logic [4:0] M_TXD = 5'b00001;
    localparam logic [4:0] M_SEL = 5'b00010;
    localparam logic [4:0] M_PUL = 5'b00100;
    localparam logic [4:0] M_PND = 5'b01000;
    localparam logic [4:0] M_DRP = 5'b10000;
    localparam logic [4:0] M_ALL = 5'b11111;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       sync_reset;
    logic [2:0] tx_in;
    logic       sel_mode;
    logic [1:0] sel_req;
    logic       TXD;
    logic [1:0] sel_current;
    logic       switch_pending;
    logic       switch_pulse;
    logic [7:0] dropped_cnt;

    uart_tx_arbiter #(
        .NUM_SRC    (NUM_SRC),
        .BAUD_PERIOD(4),
        .GUARD_BITS (2),
        .DEFAULT_SEL(0)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .sync_reset    (sync_reset),
        .tx_in         (tx_in),
        .sel_mode      (sel_mode),
        .sel_req       (sel_req),
        .TXD           (TXD),
        .sel_current   (sel_current),
        .switch_pending(switch_pending),
        .switch_pulse  (switch_pulse),
        .dropped_cnt   (dropped_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         tag;
        string      name;
        logic [4:0] mask;
        logic       txd;
        logic [1:0] sel;
        logic       pul;
        logic       pnd;
        logic [7:0] drp;
    } exp_t;

    exp_t exp_q[$];
    int   sw_q[$];
    int   edge_n = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compare every expectation tagged for the edge just taken.
    always @(posedge clk) begin : monitor
        exp_t e;
        int   exp_sel;
        #1;
        while (exp_q.size() > 0 && exp_q[0].tag <= edge_n) begin
            e = exp_q.pop_front();
            if (e.tag != edge_n) check({e.name, "_late"}, e.tag, edge_n);
            if (e.mask[0]) check({e.name, "_txd"},     TXD,            e.txd);
            if (e.mask[1]) check({e.name, "_sel"},     sel_current,    e.sel);
            if (e.mask[2]) check({e.name, "_pulse"},   switch_pulse,   e.pul);
            if (e.mask[3]) check({e.name, "_pending"}, switch_pending, e.pnd);
            if (e.mask[4]) check({e.name, "_dropped"}, dropped_cnt,    e.drp);
        end
        if (switch_pulse) begin
            exp_sel = (sw_q.size() > 0) ? sw_q.pop_front() : -1;
            check("switch_event_sel", sel_current, exp_sel);
        end
    end

    task automatic drive(input logic [2:0] tx);
        tx_in = tx;
        @(posedge clk);
        #3;
    endtask

    task automatic step(input string name, input logic [2:0] tx, input logic [4:0] m,
                        input logic txd_e, input logic [1:0] sel_e, input logic pul_e,
                        input logic pnd_e, input logic [7:0] drp_e);
        exp_t e;
        e.tag  = edge_n + 1;
        e.name = name;
        e.mask = m;
        e.txd  = txd_e;
        e.sel  = sel_e;
        e.pul  = pul_e;
        e.pnd  = pnd_e;
        e.drp  = drp_e;
        exp_q.push_back(e);
        drive(tx);
    endtask

    // Bit j (0..9) of an 8N1 frame carrying d, LSB first.
    function automatic logic frame_bit(input logic [7:0] d, input int j);
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return d[j-1];
    endfunction

    initial begin
        logic b;
        int   d;
        reset_n    = 1'b0;
        sync_reset = 1'b0;
        tx_in      = 3'b111;
        sel_mode   = 1'b0;
        sel_req    = 2'd0;

        // ---- 1. Reset ----
        repeat (2) step("por", 3'b111, M_ALL, 1'b1, 2'd0, 1'b0, 1'b0, 8'd0);
        reset_n = 1'b1;
        repeat (10) step("warm", 3'b111, M_TXD | M_SEL | M_DRP, 1'b1, 2'd0, 1'b0, 1'b0, 8'd0);
        // Source 0 (owner) and source 1 both start; source 1 is dropped.
        step("pre_drop", 3'b100, M_TXD | M_SEL | M_DRP, 1'b0, 2'd0, 1'b0, 1'b0, 8'd1);
        step("pre_hold", 3'b100, M_TXD | M_DRP, 1'b0, 2'd0, 1'b0, 1'b0, 8'd1);
        reset_n = 1'b0;
        #1;
        check("async_rst_txd", TXD, 1'b1);
        check("async_rst_sel", sel_current, 2'd0);
        check("async_rst_dropped", dropped_cnt, 8'd0);
        repeat (2) step("rst_hold", 3'b111, M_ALL, 1'b1, 2'd0, 1'b0, 1'b0, 8'd0);
        sel_req = 2'd1;
        reset_n = 1'b1;
        repeat (7) step("s1_pending", 3'b111, M_ALL, 1'b1, 2'd0, 1'b0, 1'b1, 8'd0);
        step("s1_guard", 3'b111, M_ALL, 1'b1, 2'd0, 1'b0, 1'b0, 8'd0);
        sw_q.push_back(1);
        step("s1_switch", 3'b111, M_ALL, 1'b1, 2'd1, 1'b1, 1'b0, 8'd0);
        step("s1_after", 3'b111, M_ALL, 1'b1, 2'd1, 1'b0, 1'b0, 8'd0);

        // ---- 2. Explicit switch blocked by an active owner ----
        sel_req = 2'd0;
        sw_q.push_back(0);
        step("s2_back", 3'b111, M_ALL, 1'b1, 2'd0, 1'b1, 1'b0, 8'd0);
        repeat (2) step("s2_idle", 3'b111, M_ALL, 1'b1, 2'd0, 1'b0, 1'b0, 8'd0);
        for (int j = 0; j < 10; j++) begin
            for (int c = 0; c < 4; c++) begin
                if (j == 3 && c == 0) sel_req = 2'd2;
                b = frame_bit(8'h55, j);
                step("s2_frame", {2'b11, b}, M_ALL, b, 2'd0, 1'b0, (j >= 3), 8'd0);
            end
        end
        for (int k = 4; k < 8; k++) begin
            step("s2_guard", 3'b111, M_ALL, 1'b1, 2'd0, 1'b0, (k < 7), 8'd0);
        end
        sw_q.push_back(2);
        step("s2_switch", 3'b111, M_ALL, 1'b1, 2'd2, 1'b1, 1'b0, 8'd0);

        // ---- 3. Auto grant with simultaneous starts ----
        sel_req = 2'd0;
        sw_q.push_back(0);
        step("s3_back", 3'b111, M_ALL, 1'b1, 2'd0, 1'b1, 1'b0, 8'd0);
        sel_mode = 1'b1;
        step("s3_idle", 3'b111, M_ALL, 1'b1, 2'd0, 1'b0, 1'b0, 8'd0);
        sw_q.push_back(1);
        step("s3_grant", 3'b001, M_ALL, 1'b0, 2'd1, 1'b1, 1'b0, 8'd1);
        step("s3_hold", 3'b001, M_ALL, 1'b0, 2'd1, 1'b0, 1'b0, 8'd1);
        step("s3_end", 3'b111, M_TXD | M_SEL | M_DRP, 1'b1, 2'd1, 1'b0, 1'b0, 8'd1);

        // ---- 4. Auto, owner busy: source 2 starts mid-frame ----
        repeat (9) step("s4_wait", 3'b111, M_TXD | M_SEL | M_DRP, 1'b1, 2'd1, 1'b0, 1'b0, 8'd1);
        for (int j = 0; j < 10; j++) begin
            for (int c = 0; c < 4; c++) begin
                b = frame_bit(8'hA3, j);
                if (j == 0 && c == 0) begin
                    sw_q.push_back(0);
                    step("s4_grant", {2'b11, b}, M_ALL, b, 2'd0, 1'b1, 1'b0, 8'd1);
                end else begin
                    step("s4_frame", {(j != 4), 1'b1, b}, M_ALL, b, 2'd0, 1'b0, 1'b0,
                         (j >= 4) ? 8'd2 : 8'd1);
                end
            end
        end

        // ---- 5. Saturation, then an out-of-range request ----
        sel_mode = 1'b0;
        step("s5_mode", 3'b111, M_ALL, 1'b1, 2'd0, 1'b0, 1'b0, 8'd2);
        for (int r = 1; r <= 150; r++) begin
            d = 2 + 2 * r;
            step("s5_fall", 3'b001, M_TXD | M_SEL | M_DRP, 1'b1, 2'd0, 1'b0, 1'b0,
                 (d > 255) ? 8'hFF : 8'(d));
            repeat (8) drive(3'b111);
        end
        sel_req = 2'd3;
        repeat (3) step("s5_bad_req", 3'b111, M_ALL, 1'b1, 2'd0, 1'b0, 1'b0, 8'hFF);

        // ---- 6. sync_reset during a frame on source 1 ----
        sel_req = 2'd1;
        sw_q.push_back(1);
        step("s6_sel1", 3'b111, M_ALL, 1'b1, 2'd1, 1'b1, 1'b0, 8'hFF);
        for (int j = 0; j < 3; j++) begin
            for (int c = 0; c < 4; c++) begin
                b = frame_bit(8'h03, j);
                step("s6_frame", {1'b1, b, 1'b1}, M_ALL, b, 2'd1, 1'b0, 1'b0, 8'hFF);
            end
        end
        sync_reset = 1'b1;
        sel_mode   = 1'b1;
        step("s6_sreset", 3'b101, M_ALL, 1'b1, 2'd0, 1'b0, 1'b0, 8'd0);
        sync_reset = 1'b0;
        repeat (2) step("s6_release", 3'b101, M_ALL, 1'b1, 2'd0, 1'b0, 1'b0, 8'd0);
        repeat (4) step("s6_early_start", 3'b001, M_ALL, 1'b1, 2'd0, 1'b0, 1'b0, 8'd0);
        repeat (4) step("s6_settle", 3'b111, M_ALL, 1'b1, 2'd0, 1'b0, 1'b0, 8'd0);

        repeat (2) drive(3'b111);
        check("exp_queue_drained", exp_q.size(), 0);
        check("switch_queue_drained", sw_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
